// File: rtl/writeback.sv
// ----------------------------------------------------------------------------
// writeback
//   Pipeline writeback stage: a MEM/WB latch followed by a 32x32 register
//   file with a write-through bypass on both read ports.
//
//   The MEM/WB latch captures on a rising edge when either hit is asserted
//   and the core has not halted. The write data is selected at capture time,
//   so wb_wdat is a registered value. The latched write commits to the
//   register file on every edge it is held; repeated commits are harmless.
//
// Ports
//   CLK, nRST          clock (rising edge) and asynchronous active-low reset
//   ihit, dhit         pipeline advance qualifiers
//   regWr, regSel,
//   regDst             MEM-stage write enable, data select, destination
//   ALUOut, dmemload,
//   nPC                write-data candidates
//   halt               MEM-stage halt
//   rsel1, rsel2       read selects
//   rdat1, rdat2       combinational read data
//   wb_regWr,
//   wb_regDst, wb_wdat latched write, exported for forwarding
//   halted             sticky halt flag
// ----------------------------------------------------------------------------
module writeback (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        regWr,
   input  logic [1:0]  regSel,
   input  logic [4:0]  regDst,
   input  logic [31:0] ALUOut,
   input  logic [31:0] dmemload,
   input  logic [31:0] nPC,
   input  logic        halt,
   input  logic [4:0]  rsel1,
   input  logic [4:0]  rsel2,
   output logic [31:0] rdat1,
   output logic [31:0] rdat2,
   output logic        wb_regWr,
   output logic [4:0]  wb_regDst,
   output logic [31:0] wb_wdat,
   output logic        halted
);

   logic [31:0] regs [32];
   logic        wb_halt;
   logic [31:0] sel_wdat;
   logic        capture;

   // A simultaneous ihit and dhit is still one advance.
   assign capture = (ihit | dhit) & ~halted;

   // NOTE: every path through always_comb assigns sel_wdat (default first),
   // so no latch is inferred.
   always_comb begin
      sel_wdat = ALUOut;
      case (regSel)
         2'd1:    sel_wdat = dmemload;
         2'd2:    sel_wdat = nPC;
         default: sel_wdat = ALUOut;  // 0 and 3 both select the ALU result
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so all
   // registers sample pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wb_regWr  <= 1'b0;
         wb_regDst <= '0;
         wb_wdat   <= '0;
         wb_halt   <= 1'b0;
         halted    <= 1'b0;
         // NOTE: the register file is cleared by reset, so it must stay in
         // flops; a RAM macro could not honour this.
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (capture) begin
            wb_regWr  <= regWr;
            wb_regDst <= regDst;
            wb_wdat   <= sel_wdat;
            wb_halt   <= halt;
         end
         if (wb_halt) begin
            halted <= 1'b1;
         end
         // Register 0 is never written; a held write recommits each edge.
         if (wb_regWr && (wb_regDst != 5'd0)) begin
            regs[wb_regDst] <= wb_wdat;
         end
      end
   end

   // Bypass makes a latched write visible in the same cycle it is latched.
   assign rdat1 = (rsel1 == 5'd0)                     ? 32'd0   :
                  (wb_regWr && (rsel1 == wb_regDst))  ? wb_wdat :
                                                        regs[rsel1];
   assign rdat2 = (rsel2 == 5'd0)                     ? 32'd0   :
                  (wb_regWr && (rsel2 == wb_regDst))  ? wb_wdat :
                                                        regs[rsel2];

endmodule

// File: tb/tb_writeback.sv
// ----------------------------------------------------------------------------
// tb_writeback
//   Directed bench for writeback. Each capture pushes the expected latch
//   contents onto a scoreboard queue; after the edge the entry is popped and
//   compared with wb_*. Read ports and halted are checked against constants.
// ----------------------------------------------------------------------------
module tb_writeback;

   typedef struct {
      logic        wr;
      logic [4:0]  dst;
      logic [31:0] wdat;
   } wb_exp_t;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ihit, dhit, regWr, halt;
   logic [1:0]  regSel;
   logic [4:0]  regDst, rsel1, rsel2;
   logic [31:0] ALUOut, dmemload, nPC;
   logic [31:0] rdat1, rdat2, wb_wdat;
   logic        wb_regWr, halted;
   logic [4:0]  wb_regDst;

   int checks = 0;
   int errors = 0;
   wb_exp_t exp_q[$];

   always #5 CLK = ~CLK;

   writeback dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .regWr(regWr),
      .regSel(regSel), .regDst(regDst), .ALUOut(ALUOut), .dmemload(dmemload),
      .nPC(nPC), .halt(halt), .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1),
      .rdat2(rdat2), .wb_regWr(wb_regWr), .wb_regDst(wb_regDst),
      .wb_wdat(wb_wdat), .halted(halted)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge; sample 1 time unit after it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic wr, input logic [4:0] dst,
                       input logic [31:0] wdat);
      wb_exp_t e;
      e.wr = wr; e.dst = dst; e.wdat = wdat;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      wb_exp_t e;
      checks++;
      assert (exp_q.size() != 0) else begin
         errors++;
         $error("FAIL %s observed empty-scoreboard expected entry", tag);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, ".wr"},   {31'd0, wb_regWr}, {31'd0, e.wr});
         check({tag, ".dst"},  {27'd0, wb_regDst}, {27'd0, e.dst});
         check({tag, ".wdat"}, wb_wdat, e.wdat);
      end
   endtask

   task automatic read_chk(input string tag, input logic [4:0] s1,
                           input logic [31:0] e1, input logic [4:0] s2,
                           input logic [31:0] e2);
      rsel1 = s1;
      rsel2 = s2;
      #1;
      check({tag, ".rdat1"}, rdat1, e1);
      check({tag, ".rdat2"}, rdat2, e2);
   endtask

   initial begin
      nRST = 1'b0; ihit = 0; dhit = 0; regWr = 0; halt = 0; regSel = 0;
      regDst = 0; rsel1 = 0; rsel2 = 0; ALUOut = 0; dmemload = 0; nPC = 0;

      // Reset state: every register reads 0, latch and halted clear.
      #12;
      for (int i = 0; i < 32; i++) begin
         read_chk("reset_rd", 5'(i), 32'd0, 5'(31 - i), 32'd0);
      end
      check("reset.halted", {31'd0, halted}, 32'd0);
      push(1'b0, 5'd0, 32'd0);
      pop_check("reset.wb");
      @(negedge CLK);
      nRST = 1'b1;
      tick();

      // ALU write to r5, visible immediately via bypass.
      regWr = 1; regDst = 5'd5; regSel = 2'd0; ALUOut = 32'hDEADBEEF; ihit = 1;
      push(1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      ihit = 0;
      pop_check("alu_wr");
      read_chk("bypass_r5", 5'd5, 32'hDEADBEEF, 5'd5, 32'hDEADBEEF);
      tick();

      // Load to r0 via dhit: discarded, r0 stays 0 even with wb_regWr=1.
      regSel = 2'd1; dmemload = 32'h1234; regDst = 5'd0; dhit = 1;
      push(1'b1, 5'd0, 32'h1234);
      tick();
      dhit = 0;
      pop_check("load_r0");
      read_chk("r0_bypass", 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
      tick();
      read_chk("r0_array", 5'd0, 32'd0, 5'd5, 32'hDEADBEEF);

      // regSel=3 selects ALUOut.
      regSel = 2'd3; regDst = 5'd3; ALUOut = 32'hA5A5A5A5;
      dmemload = 32'h0BAD0BAD; nPC = 32'h0BAD0BAD; ihit = 1;
      push(1'b1, 5'd3, 32'hA5A5A5A5);
      tick();
      ihit = 0;
      pop_check("sel3");

      // Link write to r7, then four idle cycles with changing inputs.
      regSel = 2'd2; regDst = 5'd7; nPC = 32'h40; ALUOut = 32'h99; ihit = 1;
      push(1'b1, 5'd7, 32'h40);
      tick();
      ihit = 0;
      pop_check("link_r7");
      regDst = 5'd9; nPC = 32'h5555; ALUOut = 32'h5555;
      for (int i = 0; i < 4; i++) begin
         push(1'b1, 5'd7, 32'h40);
         tick();
         pop_check("idle_hold");
      end
      read_chk("r7_held", 5'd7, 32'h40, 5'd9, 32'd0);
      read_chk("others", 5'd5, 32'hDEADBEEF, 5'd3, 32'hA5A5A5A5);

      // ihit and dhit together on consecutive cycles: one capture each.
      regSel = 2'd0; ihit = 1; dhit = 1;
      regDst = 5'd10; ALUOut = 32'h111;
      push(1'b1, 5'd10, 32'h111);
      tick();
      pop_check("both_hit1");
      regDst = 5'd11; ALUOut = 32'h222;
      push(1'b1, 5'd11, 32'h222);
      tick();
      pop_check("both_hit2");
      ihit = 0; dhit = 0; regWr = 0;
      tick();
      read_chk("both_regs", 5'd10, 32'h111, 5'd11, 32'h222);

      // Halt: captured, halted next edge, latch then frozen.
      regWr = 1; halt = 1; regDst = 5'd12; ALUOut = 32'hC0DE; ihit = 1;
      push(1'b1, 5'd12, 32'hC0DE);
      tick();
      ihit = 0; halt = 0;
      pop_check("halt_cap");
      check("halted_pre", {31'd0, halted}, 32'd0);
      tick();
      check("halted_set", {31'd0, halted}, 32'd1);
      regDst = 5'd13; ALUOut = 32'hBAD; ihit = 1; dhit = 1;
      for (int i = 0; i < 2; i++) begin
         push(1'b1, 5'd12, 32'hC0DE);
         tick();
         pop_check("frozen");
      end
      check("halted_sticky", {31'd0, halted}, 32'd1);
      regWr = 0;
      tick();
      regWr = 1;
      read_chk("frozen_rd", 5'd12, 32'hC0DE, 5'd13, 32'd0);

      // Mid-operation reset discards the held write and clears everything.
      ihit = 0; dhit = 0;
      nRST = 1'b0;
      #2;
      check("rst_halted", {31'd0, halted}, 32'd0);
      push(1'b0, 5'd0, 32'd0);
      pop_check("rst_wb");
      read_chk("rst_rd", 5'd7, 32'd0, 5'd12, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;

      // Resume on the first qualifying edge.
      regDst = 5'd14; ALUOut = 32'h77; regSel = 2'd0; ihit = 1;
      push(1'b1, 5'd14, 32'h77);
      tick();
      ihit = 0;
      pop_check("resume");
      tick();
      read_chk("resume_rd", 5'd14, 32'h77, 5'd7, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 SHALL have ports (name direction width meaning), clock and reset first:
- CLK  in  1  clock, rising-edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  instruction fetch complete; pipeline advance.
- dhit  in  1  data access complete; load data valid.
- regWr  in  1  MEM-stage register write enable.
- regSel  in  2  write-data select: 0 ALUOut, 1 dmemload, 2 nPC, 3 ALUOut.
- regDst  in  5  MEM-stage destination register.
- ALUOut  in  32  MEM-stage ALU result.
- dmemload  in  32  data memory read data.
- nPC  in  32  link address.
- halt  in  1  MEM-stage halt.
- rsel1, rsel2  in  5 each  ID-stage read selects.
- rdat1, rdat2  out  32 each  read data.
- wb_regWr  out  1  latched write enable (forwarding).
- wb_regDst  out  5  latched destination.
- wb_wdat  out  32  latched write data.
- halted  out  1  sticky halt.

Function
REQ-002 SHALL contain a MEM/WB latch holding regWr, regDst, write data and halt, driven onto wb_regWr, wb_regDst, wb_wdat.
REQ-003 SHALL capture the latch on a rising CLK edge when (ihit | dhit) and halted=0; otherwise hold.
REQ-004 SHALL resolve write data at capture time per regSel, so wb_wdat is a registered 32-bit value; regSel=3 behaves as 0.
REQ-005 SHALL contain a 32x32 register file; register 0 is never written and always reads 0.
REQ-006 SHALL write wb_wdat to entry wb_regDst on every rising edge where wb_regWr=1 and wb_regDst!=0; repeated writes of a held entry are idempotent.
REQ-007 SHALL drive rdat1/rdat2 combinationally: rselN=0 -> 0; else if wb_regWr=1 and rselN=wb_regDst -> wb_wdat (write-through bypass); else stored entry.
REQ-008 SHALL set halted on the first edge where latched halt=1; once set, halted stays 1 until reset.
REQ-009 SHALL freeze the latch once halted=1; the held write still commits per REQ-006.
REQ-010 SHALL, when ihit and dhit are both 1 in one cycle, perform a single capture (no double advance).
REQ-011 SHALL give both read ports identical behaviour, including when rsel1=rsel2.
REQ-012 SHALL have one-cycle latency from MEM inputs to wb_* outputs, and zero-cycle latency from a latched write to rdat via bypass.

Reset
REQ-013 SHALL, on nRST low, asynchronously clear wb_regWr, wb_regDst, wb_wdat, the latched halt, halted and all 32 registers to 0.
REQ-014 SHALL treat reset asserted mid-operation as overriding capture and write on that edge; a write pending in the latch is discarded.
REQ-015 SHALL resume normal capture on the first qualifying edge after nRST deasserts.

Verification
REQ-016 Reset, then read all rsel values -> rdat1=rdat2=0; halted=0; wb_* = 0.
REQ-017 regWr=1, regDst=5, regSel=0, ALUOut=0xDEADBEEF, pulse ihit -> next cycle wb_wdat=0xDEADBEEF; rsel1=5 gives 0xDEADBEEF via bypass and from the array after the following edge.
REQ-018 regSel=1, dmemload=0x1234, regDst=0, pulse dhit -> register 0 stays 0; rsel2=0 reads 0 despite wb_regWr=1.
REQ-019 No ihit/dhit for 4 cycles after a capture of regDst=7, regSel=2, nPC=0x40 -> latch holds; r7=0x40; no other register changes.
REQ-020 halt=1 captured -> halted=1 next edge; further ihit with new regDst/ALUOut -> latch unchanged; nRST pulse -> halted=0, r7=0.
REQ-021 ihit and dhit asserted together with distinct ALUOut values on consecutive cycles -> exactly one capture per cycle, wb_wdat follows the inputs.
